// File: rtl/ifid_pkg.sv
// Shared fetch/decode types.
//   fetch_entry_t : one queued fetch result (PC, instruction word, address-error flag)
//   NOP_INSTR     : word presented to decode for empty or faulting slots (SLL $0)
package ifid_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/ibuf_ram.sv
// Storage for the instruction buffer: DEPTH entries of fetch_entry_t.
// One synchronous write port, one asynchronous read port. Contents are not reset;
// the owner tracks which slots are valid.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational)
module ibuf_ram
  import ifid_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  fetch_entry_t      wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output fetch_entry_t      rdata_o
);

  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_buffer.sv
// Fetch-to-decode instruction queue.
// Buffers I-cache responses in front of the decoder so fetch latency and decode stalls
// are decoupled. A flush discards everything queued (wrong-path fetches). Empty or
// faulting head slots present NOP_INSTR so decode stays benign.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : empty the queue at the next edge; overrides push/pop
//   in_valid/in_ready, in_pc/in_instr/in_adel : fetch side
//   out_valid/out_ready, out_pc/out_instr/out_adel : decode side (head entry)
//   count         : occupancy, 0..DEPTH
module inst_buffer
  import ifid_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  input  logic             in_adel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic             out_adel,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   CntFull = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CntOne  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;

  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  fetch_entry_t wr_entry;
  fetch_entry_t head;

  // Full/empty come from the registered count only, so in_ready has no
  // combinational path from out_ready: a full queue refuses even if it pops.
  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);

  assign in_ready  = ~full;
  assign out_valid = ~empty;

  assign push = in_valid & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  assign wr_entry = '{pc: in_pc, instr: in_instr, adel: in_adel};

  ibuf_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  // rst covers the rst+flush case too: both clear the same state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is unreset, so everything is gated by out_valid. A faulting entry keeps
  // its PC visible (for EPC/BadVAddr) but never hands its word to decode.
  always_comb begin
    out_pc    = '0;
    out_instr = NOP_INSTR;
    out_adel  = 1'b0;
    if (out_valid) begin
      out_pc   = head.pc;
      out_adel = head.adel;
      if (!head.adel) begin
        out_instr = head.instr;
      end
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_inst_buffer.sv
module tb_inst_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic [31:0]      in_instr;
  logic             in_adel;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic             out_adel;
  logic [PTR_W:0]   count;

  int n_pass  = 0;
  int n_total = 0;

  inst_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_adel   (in_adel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_adel  (out_adel),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic adel);
    in_valid = v;
    in_pc    = pc;
    in_instr = ins;
    in_adel  = adel;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid);
    else n_pass++;
    n_total++; if (out_instr !== 32'h0) $display("FAIL reset_instr got=%h exp=0", out_instr);
    else n_pass++;
    n_total++; if (out_pc !== 32'h0) $display("FAIL reset_pc got=%h exp=0", out_pc);
    else n_pass++;
    n_total++; if (out_adel !== 1'b0) $display("FAIL reset_adel got=%b exp=0", out_adel);
    else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", in_ready);
    else n_pass++;
    n_total++; if (count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", count);
    else n_pass++;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    set_in(1'b1, 32'hBFC0_0000, 32'h2408_0001, 1'b0);
    tick();
    set_in(1'b0, 32'h0, 32'h0, 1'b0);
    n_total++; if (out_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", out_valid);
    else n_pass++;
    n_total++; if (out_pc !== 32'hBFC0_0000)
      $display("FAIL single_pc got=%h exp=bfc00000", out_pc);
    else n_pass++;
    n_total++; if (out_instr !== 32'h2408_0001)
      $display("FAIL single_instr got=%h exp=24080001", out_instr);
    else n_pass++;
    n_total++; if (count !== 4'd1) $display("FAIL single_count1 got=%0d exp=1", count);
    else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL single_popped got=%b exp=0", out_valid);
    else n_pass++;
    n_total++; if (count !== 4'd0) $display("FAIL single_count0 got=%0d exp=0", count);
    else n_pass++;
  endtask

  task automatic test_fill();
    logic [31:0] epc [9];
    logic [31:0] ein [9];
    for (int i = 0; i < 9; i++) begin
      epc[i] = 32'h0000_0100 + 32'(i * 4);
      ein[i] = 32'hA000_0000 + 32'(i);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, epc[i], ein[i], 1'b0);
      tick();
    end
    n_total++; if (count !== 4'd8) $display("FAIL fill_count got=%0d exp=8", count);
    else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL fill_ready got=%b exp=0", in_ready);
    else n_pass++;
    set_in(1'b1, epc[8], ein[8], 1'b0);
    tick(); tick();
    n_total++; if (count !== 4'd8) $display("FAIL fill_hold_count got=%0d exp=8", count);
    else n_pass++;
    n_total++; if (out_pc !== epc[0]) $display("FAIL fill_head got=%h exp=%h", out_pc, epc[0]);
    else n_pass++;
    out_ready = 1'b1;
    tick();  // pop e0, 9th refused (was full)
    n_total++; if (count !== 4'd7) $display("FAIL fill_pop1_count got=%0d exp=7", count);
    else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL fill_pop1_ready got=%b exp=1", in_ready);
    else n_pass++;
    tick();  // pop e1, push 9th
    set_in(1'b0, 32'h0, 32'h0, 1'b0);
    n_total++; if (count !== 4'd7) $display("FAIL fill_pushpop_count got=%0d exp=7", count);
    else n_pass++;
    for (int i = 2; i < 9; i++) begin
      n_total++;
      if (out_valid !== 1'b1 || out_pc !== epc[i] || out_instr !== ein[i])
        $display("FAIL drain_%0d got=%b/%h/%h exp=1/%h/%h", i, out_valid, out_pc, out_instr,
                 epc[i], ein[i]);
      else n_pass++;
      tick();
    end
    n_total++; if (out_valid !== 1'b0 || count !== 4'd0)
      $display("FAIL drain_empty got=%b/%0d exp=0/0", out_valid, count);
    else n_pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 32'h0000_2000 + 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b0);
      tick();
    end
    n_total++; if (count !== 4'd5) $display("FAIL flush_pre_count got=%0d exp=5", count);
    else n_pass++;
    flush = 1'b1;
    set_in(1'b1, 32'h0000_DEAD, 32'hDEAD_BEEF, 1'b0);
    tick();
    flush = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 1'b0);
    n_total++; if (count !== 4'd0) $display("FAIL flush_count got=%0d exp=0", count);
    else n_pass++;
    n_total++; if (out_valid !== 1'b0 || out_instr !== 32'h0)
      $display("FAIL flush_out got=%b/%h exp=0/0", out_valid, out_instr);
    else n_pass++;
    set_in(1'b1, 32'h0000_3000, 32'h1234_5678, 1'b0);
    tick();
    set_in(1'b0, 32'h0, 32'h0, 1'b0);
    n_total++; if (out_valid !== 1'b1 || out_pc !== 32'h0000_3000 || out_instr !== 32'h1234_5678
                   || count !== 4'd1)
      $display("FAIL flush_after got=%b/%h/%h/%0d exp=1/00003000/12345678/1",
               out_valid, out_pc, out_instr, count);
    else n_pass++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_adel();
    out_ready = 1'b0;
    set_in(1'b1, 32'hBFC0_0002, 32'h8C02_0000, 1'b1);
    tick();
    set_in(1'b0, 32'h0, 32'h0, 1'b0);
    n_total++; if (out_valid !== 1'b1 || out_instr !== 32'h0 || out_adel !== 1'b1
                   || out_pc !== 32'hBFC0_0002)
      $display("FAIL adel_head got=%b/%h/%b/%h exp=1/00000000/1/bfc00002",
               out_valid, out_instr, out_adel, out_pc);
    else n_pass++;
    out_ready = 1'b1;
    tick();
    n_total++; if (count !== 4'd0 || out_adel !== 1'b0)
      $display("FAIL adel_pop got=%0d/%b exp=0/0", count, out_adel);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 3 * DEPTH; k++) begin
      set_in(1'b1, 32'h0001_0000 + 32'(k * 4), 32'hC000_0000 + 32'(k * 3), 1'b0);
      tick();
      n_total++;
      if (out_valid !== 1'b1 || count !== 4'd1 || out_pc !== 32'h0001_0000 + 32'(k * 4)
          || out_instr !== 32'hC000_0000 + 32'(k * 3))
        $display("FAIL stream_%0d got=%b/%0d/%h/%h exp=1/1/%h/%h", k, out_valid, count,
                 out_pc, out_instr, 32'h0001_0000 + 32'(k * 4), 32'hC000_0000 + 32'(k * 3));
      else n_pass++;
    end
    set_in(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    n_total++; if (out_valid !== 1'b0 || count !== 4'd0)
      $display("FAIL stream_end got=%b/%0d exp=0/0", out_valid, count);
    else n_pass++;
  endtask

  task automatic test_rst_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h0000_4000 + 32'(i * 4), 32'hD000_0000 + 32'(i), 1'b0);
      tick();
    end
    rst = 1'b1; flush = 1'b1;
    set_in(1'b1, 32'h0000_5000, 32'hEEEE_EEEE, 1'b0);
    tick();
    rst = 1'b0; flush = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 1'b0);
    n_total++; if (count !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rstflush got=%0d/%b/%b exp=0/0/1", count, out_valid, in_ready);
    else n_pass++;
    set_in(1'b1, 32'h0000_6000, 32'h6666_0000, 1'b0);
    tick();
    set_in(1'b0, 32'h0, 32'h0, 1'b0);
    n_total++; if (out_pc !== 32'h0000_6000 || out_instr !== 32'h6666_0000)
      $display("FAIL rstflush_after got=%h/%h exp=00006000/66660000", out_pc, out_instr);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_flush();
    test_adel();
    test_back_to_back();
    test_rst_flush();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
